// File: rtl/kf8253_bus_master.sv
// kf8253_bus_master: expands program/read commands into KF8253 CPU-port
// bus cycles (control word, count bytes, counter latch and read-back) with
// parameterised setup / strobe / hold timing. All bus and response outputs
// are registered; only cmd_ready is a direct state decode.
`timescale 1ns/1ps
module kf8253_bus_master #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic        clock,
   input  logic        reset_in,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [1:0]  cmd_counter,
   input  logic [1:0]  cmd_rw,
   input  logic [2:0]  cmd_mode,
   input  logic        cmd_bcd,
   input  logic [15:0] cmd_count,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_error,
   output logic        chip_select_n,
   output logic        read_enable_n,
   output logic        write_enable_n,
   output logic [1:0]  address,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV, DONE, ERR} state_t;

   localparam int CW = 8;
   localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

   // Access kinds within one command: control/latch word, LSB byte, MSB byte.
   localparam logic [1:0] ACC_CTRL = 2'd0;
   localparam logic [1:0] ACC_LSB  = 2'd1;
   localparam logic [1:0] ACC_MSB  = 2'd2;

   state_t         state_q, state_d;
   logic [1:0]     acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     lsb_q, lsb_d, msb_q, msb_d;
   logic [1:0]     rw_mem_q [3];

   logic           op_q, bcd_q;
   logic [1:0]     ctr_q, rw_q;
   logic [2:0]     mode_q;
   logic [15:0]    count_q;

   logic           cs_n_q, cs_n_d, re_n_q, re_n_d, we_n_q, we_n_d, oe_q, oe_d;
   logic [1:0]     addr_q, addr_d;
   logic [7:0]     dout_q, dout_d;
   logic           rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
   logic [15:0]    rsp_data_q, rsp_data_d;

   logic           accept, legal, cur_write, nxt_write, in_acc;
   logic           eff_op, eff_bcd;
   logic [1:0]     eff_ctr, eff_rw, rw_coerced;
   logic [2:0]     eff_mode;
   logic [15:0]    eff_count;

   // Stored access mode of a counter; counter 3 never reaches a bus cycle.
   function automatic logic [1:0] rw_lookup(input logic [1:0] ctr,
                                            input logic [1:0] m0,
                                            input logic [1:0] m1,
                                            input logic [1:0] m2);
      case (ctr)
         2'd0:    rw_lookup = m0;
         2'd1:    rw_lookup = m1;
         2'd2:    rw_lookup = m2;
         default: rw_lookup = 2'b11;
      endcase
   endfunction

   assign cmd_ready      = (state_q == IDLE);
   assign accept         = cmd_ready && cmd_valid;
   assign legal          = (cmd_counter != 2'd3);
   assign rw_coerced     = (cmd_rw == 2'b00) ? 2'b11 : cmd_rw;

   // On the accept edge the command fields come straight from cmd_*.
   assign eff_op    = accept ? cmd_op      : op_q;
   assign eff_ctr   = accept ? cmd_counter : ctr_q;
   assign eff_mode  = accept ? cmd_mode    : mode_q;
   assign eff_bcd   = accept ? cmd_bcd     : bcd_q;
   assign eff_count = accept ? cmd_count   : count_q;
   assign eff_rw    = !accept ? rw_q :
                      (cmd_op ? rw_lookup(cmd_counter, rw_mem_q[0], rw_mem_q[1], rw_mem_q[2])
                              : rw_coerced);

   assign cur_write = !op_q || (acc_q == ACC_CTRL);

   // Next-state sequencing, read capture and registered-output next values.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      lsb_d       = lsb_q;
      msb_d       = msb_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (!legal) begin
                  state_d = ERR;
               end else begin
                  state_d = SETUP;
                  acc_d   = ACC_CTRL;
                  cnt_d   = '0;
                  lsb_d   = 8'h00;
                  msb_d   = 8'h00;
               end
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
               if (!cur_write) begin
                  if (acc_q == ACC_LSB) lsb_d = data_in;
                  else                  msb_d = data_in;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = RECOV;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RECOV: begin
            if (acc_q == ACC_CTRL && rw_q[0]) begin
               state_d = SETUP;
               acc_d   = ACC_LSB;
            end else if (acc_q != ACC_MSB && rw_q[1]) begin
               state_d = SETUP;
               acc_d   = ACC_MSB;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_acc    = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      nxt_write = !eff_op || (acc_d == ACC_CTRL);
      cs_n_d    = !in_acc;
      we_n_d    = !((state_d == STROBE) && nxt_write);
      re_n_d    = !((state_d == STROBE) && !nxt_write);
      oe_d      = in_acc && nxt_write;
      addr_d    = addr_q;
      dout_d    = dout_q;
      if (in_acc) begin
         addr_d = (acc_d == ACC_CTRL) ? 2'd3 : eff_ctr;
         if (nxt_write) begin
            case (acc_d)
               ACC_CTRL: dout_d = eff_op ? {eff_ctr, 6'b000000}
                                         : {eff_ctr, eff_rw, eff_mode, eff_bcd};
               ACC_LSB:  dout_d = eff_count[7:0];
               default:  dout_d = eff_count[15:8];
            endcase
         end
      end

      rsp_valid_d = (state_q == DONE) || (state_q == ERR);
      rsp_error_d = (state_q == ERR);
      rsp_data_d  = (state_q == DONE) ? {msb_q, lsb_q} : 16'h0000;
   end

   // Control state, access-mode memory and registered outputs.
   always_ff @(posedge clock or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= IDLE;
         acc_q       <= ACC_CTRL;
         cnt_q       <= '0;
         lsb_q       <= 8'h00;
         msb_q       <= 8'h00;
         for (int i = 0; i < 3; i++) rw_mem_q[i] <= 2'b11;
         cs_n_q      <= 1'b1;
         re_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_q        <= 1'b0;
         addr_q      <= 2'd0;
         dout_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         lsb_q       <= lsb_d;
         msb_q       <= msb_d;
         if (accept && legal && !cmd_op) begin
            for (int i = 0; i < 3; i++)
               if (cmd_counter == 2'(i)) rw_mem_q[i] <= rw_coerced;
         end
         cs_n_q      <= cs_n_d;
         re_n_q      <= re_n_d;
         we_n_q      <= we_n_d;
         oe_q        <= oe_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Command fields held for the duration of the bus sequence.
   always_ff @(posedge clock) begin
      if (accept) begin
         op_q    <= cmd_op;
         ctr_q   <= cmd_counter;
         rw_q    <= eff_rw;
         mode_q  <= cmd_mode;
         bcd_q   <= cmd_bcd;
         count_q <= cmd_count;
      end
   end

   assign chip_select_n  = cs_n_q;
   assign read_enable_n  = re_n_q;
   assign write_enable_n = we_n_q;
   assign data_oe        = oe_q;
   assign address        = addr_q;
   assign data_out       = dout_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_error      = rsp_error_q;
   assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_kf8253_bus_master.sv
// Scoreboard bench for kf8253_bus_master: a command-level model predicts
// the bus transfers and responses; a monitor consumes them as they appear.
`timescale 1ns/1ps
module tb_kf8253_bus_master;

   localparam int S = 1;
   localparam int T = 2;
   localparam int H = 1;
   localparam int A = S + T + H + 1;

   logic        clock;
   logic        reset_in;
   logic        cmd_valid, cmd_ready, cmd_op, cmd_bcd;
   logic [1:0]  cmd_counter, cmd_rw;
   logic [2:0]  cmd_mode;
   logic [15:0] cmd_count;
   logic        rsp_valid, rsp_error;
   logic [15:0] rsp_data;
   logic        chip_select_n, read_enable_n, write_enable_n, data_oe;
   logic [1:0]  address;
   logic [7:0]  data_out, data_in;

   kf8253_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
      .clock(clock), .reset_in(reset_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_counter(cmd_counter), .cmd_rw(cmd_rw), .cmd_mode(cmd_mode),
      .cmd_bcd(cmd_bcd), .cmd_count(cmd_count),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
      .write_enable_n(write_enable_n), .address(address),
      .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
   );

   typedef struct {bit wr; int addr; int data;} bus_t;
   typedef struct {int data; int err; int lat; longint t;} rsp_t;

   bus_t exp_bus[$];
   rsp_t exp_rsp[$];
   int   rwm [3];
   int   checks = 0;
   int   errors = 0;
   int   rsp_count = 0;
   int   setup_cnt = 0, strb_cnt = 0;
   bit   in_strb = 0, post_strb = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One monitor step per falling clock edge: bus transfers and responses.
   task automatic monitor_step();
      bus_t b;
      rsp_t r;
      chk("strobes_exclusive", int'(!write_enable_n && !read_enable_n), 0);
      chk("oe_during_read", int'(data_oe && !read_enable_n), 0);
      if (chip_select_n) begin
         setup_cnt = 0; strb_cnt = 0; in_strb = 0; post_strb = 0;
      end else if (!write_enable_n || !read_enable_n) begin
         if (!in_strb) begin
            in_strb  = 1;
            strb_cnt = 0;
            chk("setup_len", setup_cnt, S);
            if (exp_bus.size() == 0) begin
               chk("unexpected_bus_cycle", 1, 0);
            end else begin
               b = exp_bus.pop_front();
               chk("bus_dir_write", int'(!write_enable_n), int'(b.wr));
               chk("bus_addr", int'(address), b.addr);
               if (b.wr) begin
                  chk("bus_wdata", int'(data_out), b.data);
                  chk("bus_oe", int'(data_oe), 1);
               end else begin
                  data_in = 8'(b.data);
               end
            end
         end
         strb_cnt++;
      end else if (in_strb) begin
         in_strb   = 0;
         post_strb = 1;
         chk("strobe_len", strb_cnt, T);
         data_in = 8'($urandom);
      end else if (!post_strb) begin
         setup_cnt++;
      end
      if (rsp_valid) begin
         rsp_count++;
         if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            r = exp_rsp.pop_front();
            chk("rsp_data", int'(rsp_data), r.data);
            chk("rsp_error", int'(rsp_error), r.err);
            chk("rsp_latency", int'(($time - r.t - 5) / 10), r.lat);
         end
      end
   endtask

   // Issue one command and push the model's predicted transfers/response.
   task automatic send(input int op, input int ctr, input int rw, input int mode,
                       input int bcd, input int cnt, input int rl, input int rm);
      int     guard = 0;
      int     erw, n, d;
      longint t;
      bus_t   b;
      rsp_t   r;
      @(negedge clock);
      while (!cmd_ready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 0, 1);
         return;
      end
      cmd_op = op[0]; cmd_counter = 2'(ctr); cmd_rw = 2'(rw);
      cmd_mode = 3'(mode); cmd_bcd = bcd[0]; cmd_count = 16'(cnt);
      cmd_valid = 1'b1;
      @(posedge clock);
      t = $time;
      #1 cmd_valid = 1'b0;
      if (ctr == 3) begin
         r = '{data: 0, err: 1, lat: 1, t: t};
         exp_rsp.push_back(r);
         return;
      end
      n = 1;
      d = 0;
      if (op == 0) begin
         erw = (rw == 0) ? 3 : rw;
         rwm[ctr] = erw;
         b = '{wr: 1, addr: 3, data: ctr * 64 + erw * 16 + mode * 2 + bcd};
         exp_bus.push_back(b);
         if (erw % 2 == 1) begin
            b = '{wr: 1, addr: ctr, data: cnt % 256};
            exp_bus.push_back(b);
            n++;
         end
         if (erw >= 2) begin
            b = '{wr: 1, addr: ctr, data: cnt / 256};
            exp_bus.push_back(b);
            n++;
         end
      end else begin
         erw = rwm[ctr];
         b = '{wr: 1, addr: 3, data: ctr * 64};
         exp_bus.push_back(b);
         if (erw % 2 == 1) begin
            b = '{wr: 0, addr: ctr, data: rl};
            exp_bus.push_back(b);
            d += rl;
            n++;
         end
         if (erw >= 2) begin
            b = '{wr: 0, addr: ctr, data: rm};
            exp_bus.push_back(b);
            d += rm * 256;
            n++;
         end
      end
      r = '{data: d, err: 0, lat: n * A + 1, t: t};
      exp_rsp.push_back(r);
   endtask

   initial begin
      int guard;
      int saved;
      reset_in = 1'b1;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_counter = 2'd0; cmd_rw = 2'd0;
      cmd_mode = 3'd0; cmd_bcd = 1'b0; cmd_count = 16'h0000; data_in = 8'h00;
      for (int i = 0; i < 3; i++) rwm[i] = 3;
      fork
         forever begin
            @(negedge clock);
            monitor_step();
         end
      join_none

      #22;
      chk("rst_cs_n", int'(chip_select_n), 1);
      chk("rst_re_n", int'(read_enable_n), 1);
      chk("rst_we_n", int'(write_enable_n), 1);
      chk("rst_oe", int'(data_oe), 0);
      chk("rst_addr", int'(address), 0);
      chk("rst_dout", int'(data_out), 0);
      chk("rst_rsp", int'({rsp_valid, rsp_error, rsp_data}), 0);
      @(negedge clock);
      reset_in = 1'b0;
      repeat (2) @(negedge clock);
      chk("idle_ready", int'(cmd_ready), 1);
      chk("idle_cs_n", int'(chip_select_n), 1);
      chk("idle_oe", int'(data_oe), 0);

      send(0, 0, 3, 3, 0, 16'h1234, 0, 0);
      send(0, 2, 1, 0, 0, 16'h00AB, 0, 0);
      send(1, 2, 0, 0, 0, 0, 8'h5A, 0);
      send(1, 1, 0, 0, 0, 0, 8'h78, 8'h56);
      send(0, 3, 3, 0, 0, 16'hFFFF, 0, 0);
      send(0, 1, 0, 5, 1, 16'hC3A5, 0, 0);
      send(1, 1, 0, 0, 0, 0, 8'hA5, 8'hC3);

      // Reset during the MSB write strobe.
      send(0, 0, 3, 2, 0, 16'hBEEF, 0, 0);
      guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (!(exp_bus.size() == 0 && !write_enable_n) && guard < 100);
      chk("msb_strobe_seen", int'(guard < 100), 1);
      #1 reset_in = 1'b1;
      #1;
      chk("midrst_cs_n", int'(chip_select_n), 1);
      chk("midrst_we_n", int'(write_enable_n), 1);
      chk("midrst_re_n", int'(read_enable_n), 1);
      chk("midrst_oe", int'(data_oe), 0);
      exp_bus.delete();
      exp_rsp.delete();
      for (int i = 0; i < 3; i++) rwm[i] = 3;
      saved = rsp_count;
      repeat (2) @(negedge clock);
      reset_in = 1'b0;
      repeat (20) @(negedge clock);
      chk("no_rsp_after_reset", rsp_count, saved);
      send(0, 1, 3, 4, 0, 16'h4321, 0, 0);
      send(1, 0, 0, 0, 0, 0, 8'h11, 8'h22);

      for (int k = 0; k < 60; k++) begin
         send(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
      end

      guard = 0;
      while ((exp_bus.size() != 0 || exp_rsp.size() != 0) && guard < 500) begin
         @(negedge clock);
         guard++;
      end
      @(negedge clock);
      chk("bus_queue_drained", exp_bus.size(), 0);
      chk("rsp_queue_drained", exp_rsp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kf8253_bus_master.md
# kf8253_bus_master

Bus initiator that programs and reads back a KF8253 programmable interval timer through its 8-bit CPU-side port. It accepts one command at a time on a valid/ready interface and expands each into the correct sequence of control-word, count-byte and latch/read bus cycles. It sits between a sequencer or soft-CPU shim and the timer's chip_select_n / read_enable_n / write_enable_n / address / data pins. Strobe timing is parameterised for slower or synchronised targets.

## Interface
- SETUP_CYCLES, default 1: clocks CS/address/write data are valid before the strobe falls (≥1).
- STROBE_CYCLES, default 2: clocks the strobe is held low (≥1).
- HOLD_CYCLES, default 1: clocks CS/address/data are held after the strobe rises (≥1).
- clock  in  1  system clock; all state changes on rising edge.
- reset_in  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  1  0 = program counter, 1 = read counter.
- cmd_counter  in  2  counter select 0..2; 3 is illegal.
- cmd_rw  in  2  program access mode: 01 LSB, 10 MSB, 11 LSB then MSB; 00 is coerced to 11.
- cmd_mode  in  3  counter mode field for the control word.
- cmd_bcd  in  1  BCD bit for the control word.
- cmd_count  in  16  initial count for program.
- rsp_valid  out  1  one-clock pulse when a command completes.
- rsp_data  out  16  read result; 0 for program commands.
- rsp_error  out  1  valid with rsp_valid; set for cmd_counter == 3.
- chip_select_n, read_enable_n, write_enable_n  out  1 each  timer bus strobes, all active-low.
- address  out  2  timer register address.
- data_out  out  8  write data to the timer.
- data_oe  out  1  data_out drive enable; the top level tri-states on it.
- data_in  in  8  read data from the timer.

## Operation
- Latched at accept: op, counter, rw (after coercion), mode, bcd, count.
- Per-counter access-mode registers rw_mem[0..2], reset 11, updated on every accepted program command.
- Program: write control word {counter, rw, mode, bcd} to address 3.
  - Then LSB = count[7:0] to address = counter if rw[0].
  - Then MSB = count[15:8] to address = counter if rw[1].
  - Order is always LSB then MSB.
- Read: write the latch command {counter, 00, 0000} to address 3, then read bytes from address = counter per rw_mem[counter].
  - rw 01 gives rsp_data = {8'h00, lsb}.
  - rw 10 gives rsp_data = {msb, 8'h00}.
  - rw 11 reads LSB then MSB and gives {msb, lsb}.
- Illegal counter (3): no bus cycles. rsp_valid and rsp_error pulse one clock after accept. rsp_data = 0. rw_mem is not modified.
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOV → (next access: SETUP | all done: DONE) → IDLE.
  - DONE drives rsp_valid for one clock.
  - ERR state: IDLE → ERR → IDLE.
- Per access:
  - SETUP: chip_select_n = 0, address valid, and for writes data_out valid with data_oe = 1. Both strobes stay high.
  - STROBE: write_enable_n or read_enable_n = 0.
  - HOLD: strobe high; chip_select_n, address, data_out and data_oe unchanged.
  - RECOV: chip_select_n = 1, data_oe = 0, exactly 1 clock.
- data_oe is never 1 while read_enable_n = 0.
- read_enable_n and write_enable_n are never low together.

## Timing
- Reset values (held asynchronously while reset_in is high):
  - State IDLE, so cmd_ready = 1.
  - chip_select_n = read_enable_n = write_enable_n = 1.
  - address = 0, data_out = 0, data_oe = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_error = 0.
  - rw_mem = 11.
- Reset mid-cycle: the bus is released at once and the in-flight command is dropped with no response.
- Access length A = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1. With defaults, A = 5.
- Latency from the accept edge to the rsp_valid rising edge = N·A + 1 clocks, where N is the number of accesses (2 or 3).
- Read data is sampled from data_in on the last clock of STROBE, at the edge where read_enable_n rises.
- All outputs are registered; no combinational path from data_in or cmd_* to outputs except cmd_ready (state decode).
- Back-to-back: the next command can be accepted on the clock after DONE; cmd_ready is low during DONE.

## Test plan
- After reset with no command: all strobes = 1, data_oe = 0, cmd_ready = 1.
- Program counter 0, rw 11, mode 3, bcd 0, count 16'h1234 → writes in order:
  - 8'h36 to address 3
  - 8'h34 to address 0
  - 8'h12 to address 0
  - rsp_valid after 16 clocks, rsp_error = 0.
- Program counter 2, rw 01, count 16'h00AB. Then read counter 2 with a model returning 8'h5A → bus does:
  - write 8'h80 to address 3
  - one read from address 2
  - rsp_data = 16'h005A after 11 clocks.
- Read counter 1 (rw_mem = 11) with the model returning 8'h78 then 8'h56 → latch write 8'h40, two reads, rsp_data = 16'h5678.
- cmd_counter = 3 → no strobe activity; one clock after accept rsp_valid = rsp_error = 1, rsp_data = 0.
- Assert reset_in during the STROBE of an MSB write → strobes and chip_select_n high and data_oe = 0 immediately, no rsp_valid. Then a new program command completes normally.
